// File: rtl/remus_block_ctrl.sv
// rtl/remus_block_ctrl.sv - per-block load/round/unload sequencer for the Remus datapath
// Optional REMUS_BLKCNT_EN adds a saturating blk_count output of completed blocks.
module remus_block_ctrl #(
    parameter int ROUNDS       = 40,
    parameter int WORDS        = 4,
    parameter int BUSWIDTHBYTE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    decrypt_in,
    input  logic                    last_blk,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    done,
    output logic                    srst,
    output logic                    xrst,
    output logic                    erst,
    output logic                    senc,
    output logic                    xenc,
    output logic                    sse,
    output logic                    xse,
    output logic                    sl,
    output logic                    correct_cnt,
    output logic [BUSWIDTHBYTE-1:0] decrypt,
    output logic [7:0]              dold,
    output logic [7:0]              dnew
`ifdef REMUS_BLKCNT_EN
    ,
    output logic [15:0]             blk_count
`endif
);

    localparam int WW = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_ROUND,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic [5:0]    rcnt, rcnt_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic          dir, last, rst_q;
    logic          word_last;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
            rcnt  <= '0;
            cnt   <= 8'h01;
            dir   <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            rcnt  <= rcnt_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && start_valid) begin
                dir  <= decrypt_in;
                last <= last_blk;
            end
        end
    end

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
    assign dold      = cnt;
    assign dnew      = {cnt[6:0], 1'b0} ^ (cnt[7] ? 8'h1D : 8'h00);
    assign decrypt   = {BUSWIDTHBYTE{dir}};
    assign srst      = rst | rst_q;
    assign xrst      = rst | rst_q;
    assign word_last = (wcnt == WW'(WORDS - 1));

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        rcnt_nxt    = rcnt;
        cnt_nxt     = cnt;
        start_ready = 1'b0;
        load_ready  = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        erst        = 1'b0;
        senc        = 1'b0;
        xenc        = 1'b0;
        sse         = 1'b0;
        xse         = 1'b0;
        sl          = 1'b0;
        correct_cnt = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = ~rst;
                if (start_valid) begin
                    wcnt_nxt  = '0;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                sse        = load_valid;
                xse        = load_valid;
                if (load_valid) begin
                    if (word_last) begin
                        wcnt_nxt  = '0;
                        state_nxt = S_INIT;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            S_INIT: begin
                erst        = 1'b1;
                correct_cnt = 1'b1;
                rcnt_nxt    = '0;
                state_nxt   = S_ROUND;
            end
            S_ROUND: begin
                senc = 1'b1;
                xenc = 1'b1;
                if (rcnt == 6'(ROUNDS - 1)) begin
                    rcnt_nxt  = '0;
                    state_nxt = S_UNLOAD;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                sl        = 1'b1;
                sse       = out_ready;
                if (out_ready) begin
                    if (word_last) begin
                        wcnt_nxt  = '0;
                        state_nxt = S_DONE;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                cnt_nxt   = last ? 8'h01 : dnew;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef REMUS_BLKCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            blk_count <= '0;
        else if (done && blk_count != 16'hFFFF)
            blk_count <= blk_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_remus_block_ctrl.sv
// tb/tb_remus_block_ctrl.sv - directed self-checking bench for remus_block_ctrl
module tb_remus_block_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_valid = 1'b0, start_ready;
    logic       decrypt_in = 1'b0, last_blk = 1'b0;
    logic       load_valid = 1'b0, load_ready;
    logic       out_valid, out_ready = 1'b0;
    logic       done, srst, xrst, erst, senc, xenc, sse, xse, sl, correct_cnt;
    logic [3:0] decrypt;
    logic [7:0] dold, dnew;
`ifdef REMUS_BLKCNT_EN
    logic [15:0] blk_count;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    remus_block_ctrl #(.ROUNDS(40), .WORDS(4), .BUSWIDTHBYTE(4)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .decrypt_in(decrypt_in), .last_blk(last_blk),
        .load_valid(load_valid), .load_ready(load_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .srst(srst), .xrst(xrst), .erst(erst),
        .senc(senc), .xenc(xenc), .sse(sse), .xse(xse), .sl(sl),
        .correct_cnt(correct_cnt), .decrypt(decrypt),
        .dold(dold), .dnew(dnew)
`ifdef REMUS_BLKCNT_EN
        , .blk_count(blk_count)
`endif
    );

    task automatic do_reset();
        rst = 1'b1;
        start_valid = 1'b0; load_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Issue one command with no stalls and return one cycle after done.
    task automatic run_block(input logic lb);
        int t;
        @(negedge clk);
        start_valid = 1'b1; last_blk = lb; decrypt_in = 1'b0;
        load_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        #1;
        for (t = 0; t < 200; t++) begin
            if (done) break;
            @(negedge clk);
            #1;
        end
        compared++;
        if (t >= 200) begin
            mismatched++;
            $display("FAIL run_block_timeout: done not seen within %0d cycles", t);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        compared++;
        if (srst !== 1'b1 || xrst !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_srst_in_rst: srst=%b xrst=%b required 1 1", srst, xrst);
        end
        do_reset();
        compared++;
        if (srst !== 1'b1 || start_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_cycle_after: srst=%b start_ready=%b required 1 1", srst, start_ready);
        end
        @(negedge clk);
        #1;
        compared++;
        if ({srst, xrst, erst, senc, xenc, sse, xse, sl, correct_cnt, load_ready, out_valid, done} !== 12'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b required 000000000000",
                     {srst, xrst, erst, senc, xenc, sse, xse, sl, correct_cnt, load_ready, out_valid, done});
        end
        compared++;
        if (start_ready !== 1'b1 || dold !== 8'h01 || dnew !== 8'h02 || decrypt !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_idle: start_ready=%b dold=%h dnew=%h decrypt=%h required 1 01 02 0",
                     start_ready, dold, dnew, decrypt);
        end
`ifdef REMUS_BLKCNT_EN
        compared++;
        if (blk_count !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_blk_count: got %0d required 0", blk_count);
        end
`endif
    endtask

    task automatic test_one_block();
        logic e_lr, e_erst, e_senc, e_ov, e_done, e_sse;
        @(negedge clk);
        start_valid = 1'b1; decrypt_in = 1'b1; last_blk = 1'b0;
        load_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            if (c > 10) start_valid = 1'b0;
            #1;
            e_lr   = (c >= 1 && c <= 4);
            e_erst = (c == 5);
            e_senc = (c >= 6 && c <= 45);
            e_ov   = (c >= 46 && c <= 49);
            e_done = (c == 50);
            e_sse  = e_lr || e_ov;
            compared++;
            if ({load_ready, erst, correct_cnt, senc, xenc, out_valid, sl, done, sse, xse} !==
                {e_lr, e_erst, e_erst, e_senc, e_senc, e_ov, e_ov, e_done, e_sse, e_lr}) begin
                mismatched++;
                $display("FAIL one_block_c%0d: lr,erst,cc,senc,xenc,ov,sl,done,sse,xse=%b required %b", c,
                         {load_ready, erst, correct_cnt, senc, xenc, out_valid, sl, done, sse, xse},
                         {e_lr, e_erst, e_erst, e_senc, e_senc, e_ov, e_ov, e_done, e_sse, e_lr});
            end
            if (c == 2) begin
                compared++;
                if (start_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL busy_start_ready: got %b required 0", start_ready);
                end
            end
            if (c == 20) begin
                compared++;
                if (decrypt !== 4'hF) begin
                    mismatched++;
                    $display("FAIL decrypt_latched: got %h required f", decrypt);
                end
            end
        end
        compared++;
        if (dold !== 8'h02 || dnew !== 8'h04 || start_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL one_block_cnt: dold=%h dnew=%h start_ready=%b required 02 04 1",
                     dold, dnew, start_ready);
        end
    endtask

    task automatic test_stall();
        int sse_n = 0, xse_n = 0, done_c = -1;
        @(negedge clk);
        start_valid = 1'b1; decrypt_in = 1'b0; last_blk = 1'b0;
        load_valid = 1'b0; out_ready = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start_valid = 1'b0;
            load_valid  = (c <= 7) ? ((c % 2) == 1) : 1'b0;
            out_ready   = !(c >= 50 && c <= 52);
            #1;
            if (sse) sse_n++;
            if (xse) xse_n++;
            if (done) done_c = c;
        end
        compared++;
        if (sse_n != 8 || xse_n != 4) begin
            mismatched++;
            $display("FAIL stall_shift_count: sse=%0d xse=%0d required 8 4", sse_n, xse_n);
        end
        compared++;
        if (done_c != 56) begin
            mismatched++;
            $display("FAIL stall_done_cycle: got %0d required 56", done_c);
        end
        compared++;
        if (dold !== 8'h04) begin
            mismatched++;
            $display("FAIL stall_cnt: dold=%h required 04", dold);
        end
    endtask

    task automatic test_mid_reset();
        int done_n = 0;
        @(negedge clk);
        start_valid = 1'b1; last_blk = 1'b0; load_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            start_valid = 1'b0;
        end
        #1;
        compared++;
        if (senc !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset_in_round: senc=%b required 1", senc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (senc !== 1'b0 || start_ready !== 1'b1 || dold !== 8'h01 || srst !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset_after: senc=%b start_ready=%b dold=%h srst=%b required 0 1 01 1",
                     senc, start_ready, dold, srst);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (done) done_n++;
        end
        compared++;
        if (done_n != 0) begin
            mismatched++;
            $display("FAIL mid_reset_no_done: done pulses=%0d required 0", done_n);
        end
    endtask

    task automatic test_last_block();
`ifdef REMUS_BLKCNT_EN
        logic [15:0] bc0;
`endif
        for (int i = 0; i < 3; i++) run_block(1'b0);
        compared++;
        if (dold !== 8'h08) begin
            mismatched++;
            $display("FAIL last_pre_cnt: dold=%h required 08", dold);
        end
`ifdef REMUS_BLKCNT_EN
        bc0 = blk_count;
`endif
        run_block(1'b1);
        compared++;
        if (dold !== 8'h01 || dnew !== 8'h02) begin
            mismatched++;
            $display("FAIL last_cnt_reset: dold=%h dnew=%h required 01 02", dold, dnew);
        end
`ifdef REMUS_BLKCNT_EN
        compared++;
        if (blk_count !== bc0 + 16'd1) begin
            mismatched++;
            $display("FAIL blk_count_inc: got %0d required %0d", blk_count, bc0 + 16'd1);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) run_block(1'b0);
        compared++;
        if (dold !== 8'h80 || dnew !== 8'h1D) begin
            mismatched++;
            $display("FAIL wrap_reduce: dold=%h dnew=%h required 80 1d", dold, dnew);
        end
        for (int i = 7; i < 254; i++) run_block(1'b0);
        compared++;
        if (dold !== 8'h8E) begin
            mismatched++;
            $display("FAIL wrap_254: dold=%h required 8e", dold);
        end
        run_block(1'b0);
        compared++;
        if (dold !== 8'h01) begin
            mismatched++;
            $display("FAIL wrap_255: dold=%h required 01", dold);
        end
    endtask

    initial begin
        test_reset();
        test_one_block();
        test_stall();
        test_mid_reset();
        test_last_block();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
